// File: rtl/line_memory.sv
// rtl/line_memory.sv - fixed-latency 256-bit line memory answering cache refill/write-back requests
module line_memory #(
    parameter int LATENCY = 10,
    parameter int IDX_W   = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o,
    output logic         busy_o
);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t             state;
    state_t             state_next;
    logic [7:0]         cnt;
    logic [IDX_W-1:0]   req_idx;
    logic               req_write;
    logic [255:0]       req_data;
    logic               done;

    logic [255:0] memory [0:(1 << IDX_W) - 1];

    // Upper address bits alias by design; byte offset within the line is irrelevant.
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:IDX_W+5], addr_i[4:0]};

    assign done = (state == WAIT) && (cnt == 8'(LATENCY));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable_i) state_next = WAIT;
            WAIT:    if (done)     state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ack_o  = 1'b0;
        busy_o = 1'b0;
        case (state)
            WAIT:    busy_o = 1'b1;
            ACK: begin
                ack_o  = 1'b1;
                busy_o = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt       <= '0;
            req_idx   <= '0;
            req_write <= 1'b0;
            req_data  <= '0;
            data_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable_i) begin
                        req_idx   <= addr_i[IDX_W+4:5];
                        req_write <= write_i;
                        req_data  <= data_i;
                        cnt       <= 8'd1;
                    end
                end
                WAIT: begin
                    if (done) begin
                        if (!req_write) data_o <= memory[req_idx];
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Array is left uninitialised on reset; a reset on the commit edge drops the write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && done && req_write) begin
            memory[req_idx] <= req_data;
        end
    end

endmodule

// File: tb/tb_line_memory.sv
// tb/tb_line_memory.sv - directed self-checking bench for line_memory
module tb_line_memory;

    localparam int LAT = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic         en1 = 1'b0;
    logic         write = 1'b0;
    logic [31:0]  addr = '0;
    logic [255:0] wdata = '0;
    logic         ack_o, busy_o, ack1, busy1;
    logic [255:0] data_o, data1;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [255:0] PAT_A5  = {32{8'hA5}};
    localparam logic [255:0] PAT_WR  = {4{64'h0123456789ABCDEF}};
    localparam logic [255:0] PAT_P   = {8{32'hDEADBEEF}};
    localparam logic [255:0] PAT_Q   = {16{16'h5A5A}};
    localparam logic [255:0] PAT_R   = {8{32'h11112222}};
    localparam logic [255:0] PAT_M2  = {4{64'hCAFEF00D12345678}};
    localparam logic [255:0] PAT_M7  = {8{32'h77777777}};
    localparam logic [255:0] PAT_M8  = {8{32'h88888888}};
    localparam logic [255:0] PAT_X   = {8{32'h0F1E2D3C}};
    localparam logic [255:0] PAT_J   = {8{32'hBADBADBA}};

    line_memory #(.LATENCY(LAT), .IDX_W(9)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .write_i(write),
        .addr_i(addr), .data_i(wdata), .ack_o(ack_o), .data_o(data_o), .busy_o(busy_o)
    );

    line_memory #(.LATENCY(1), .IDX_W(9)) dut1 (
        .clk_i(clk), .rst_i(rst), .enable_i(en1), .write_i(write),
        .addr_i(addr), .data_i(wdata), .ack_o(ack1), .data_o(data1), .busy_o(busy1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", tag, observed, expected);
        end
    endtask

    // Issue one request at the next edge and watch for edges cycles; drop enable after
    // acceptance, or after the ack when hold is set.
    task automatic run_req(input logic w, input logic [31:0] a, input logic [255:0] d,
                           input bit hold, input int edges,
                           output int lat, output int nack, output int nbusy,
                           output logic [255:0] rd);
        enable = 1'b1; write = w; addr = a; wdata = d;
        lat = -1; nack = 0; nbusy = 0; rd = '0;
        for (int k = 0; k < edges; k++) begin
            @(posedge clk); #1;
            if (busy_o) nbusy++;
            if (ack_o) begin
                nack++;
                if (lat < 0) begin
                    lat = k;
                    rd  = data_o;
                end
                if (hold) enable = 1'b0;
            end
            if (!hold) enable = 1'b0;
        end
        enable = 1'b0;
        write  = 1'b0;
    endtask

    int lat, nack, nbusy;
    logic [255:0] rd;
    int ack_times[$];
    bit back_to_back;
    bit prev_ack;

    initial begin
        dut.memory[2]  = PAT_M2;
        dut.memory[3]  = PAT_A5;
        dut.memory[5]  = PAT_R;
        dut.memory[7]  = PAT_M7;
        dut.memory[8]  = PAT_M8;
        dut1.memory[0] = PAT_X;

        repeat (2) @(posedge clk);
        #1;
        check("reset_ack", 256'(ack_o), 256'(0));
        check("reset_busy", 256'(busy_o), 256'(0));
        check("reset_data", data_o, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Read latency from idx 3
        run_req(1'b0, 32'h60, '0, 1'b0, LAT + 4, lat, nack, nbusy, rd);
        check("rd_latency", 256'(lat), 256'(10));
        check("rd_ack_count", 256'(nack), 256'(1));
        check("rd_busy_cycles", 256'(nbusy), 256'(11));
        check("rd_data", rd, PAT_A5);

        // Write with enable held until ack, then read back
        run_req(1'b1, 32'h0000_1000, PAT_WR, 1'b1, LAT + 4, lat, nack, nbusy, rd);
        check("wr_latency", 256'(lat), 256'(10));
        check("wr_ack_count", 256'(nack), 256'(1));
        check("wr_data_hold", data_o, PAT_A5);
        run_req(1'b0, 32'h0000_1000, '0, 1'b0, LAT + 4, lat, nack, nbusy, rd);
        check("wrrb_ack_count", 256'(nack), 256'(1));
        check("wrrb_data", rd, PAT_WR);

        // Alias through high and low address bits
        run_req(1'b1, 32'h0000_0020, PAT_P, 1'b0, LAT + 4, lat, nack, nbusy, rd);
        run_req(1'b0, 32'h0000_4020, '0, 1'b0, LAT + 4, lat, nack, nbusy, rd);
        check("alias_high", rd, PAT_P);
        run_req(1'b0, 32'h0000_003F, '0, 1'b0, LAT + 4, lat, nack, nbusy, rd);
        check("alias_low", rd, PAT_P);

        // Enable held continuously: one acceptance every LAT+2 edges
        enable = 1'b1; write = 1'b0; addr = 32'h40;
        back_to_back = 1'b0; prev_ack = 1'b0;
        for (int k = 0; k < 36; k++) begin
            @(posedge clk); #1;
            if (ack_o) begin
                ack_times.push_back(k);
                check("held_data", data_o, PAT_M2);
                if (prev_ack) back_to_back = 1'b1;
            end
            prev_ack = ack_o;
        end
        enable = 1'b0;
        check("held_ack_count", 256'(ack_times.size()), 256'(3));
        if (ack_times.size() == 3) begin
            check("held_first", 256'(ack_times[0]), 256'(10));
            check("held_spacing1", 256'(ack_times[1] - ack_times[0]), 256'(LAT + 2));
            check("held_spacing2", 256'(ack_times[2] - ack_times[1]), 256'(LAT + 2));
        end
        check("held_no_b2b", 256'(back_to_back), 256'(0));
        repeat (LAT + 3) @(posedge clk);
        #1;

        // Reset at E4 of a write to idx 5
        enable = 1'b1; write = 1'b1; addr = 32'hA0; wdata = PAT_Q;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            enable = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; write = 1'b0;
        check("rstmid_ack", 256'(ack_o), 256'(0));
        check("rstmid_busy", 256'(busy_o), 256'(0));
        check("rstmid_data", data_o, '0);
        nack = 0;
        for (int k = 0; k < LAT + 4; k++) begin
            @(posedge clk); #1;
            if (ack_o) nack++;
        end
        check("rstmid_no_ack", 256'(nack), 256'(0));
        run_req(1'b0, 32'hA0, '0, 1'b0, LAT + 4, lat, nack, nbusy, rd);
        check("rstmid_old_value", rd, PAT_R);

        // Inputs changed during WAIT must be ignored
        enable = 1'b1; write = 1'b0; addr = 32'hE0;
        @(posedge clk); #1;
        enable = 1'b0; write = 1'b1; addr = 32'h100; wdata = PAT_J;
        lat = -1; rd = '0;
        for (int k = 1; k < LAT + 4; k++) begin
            @(posedge clk); #1;
            if (ack_o && lat < 0) begin
                lat = k;
                rd  = data_o;
            end
        end
        write = 1'b0;
        check("chg_latency", 256'(lat), 256'(10));
        check("chg_data", rd, PAT_M7);
        run_req(1'b0, 32'h100, '0, 1'b0, LAT + 4, lat, nack, nbusy, rd);
        check("chg_idx8_intact", rd, PAT_M8);

        // LATENCY=1 instance
        write = 1'b0; addr = 32'h0; en1 = 1'b1;
        @(posedge clk); #1;
        en1 = 1'b0;
        check("lat1_e0_ack", 256'(ack1), 256'(0));
        check("lat1_e0_busy", 256'(busy1), 256'(1));
        @(posedge clk); #1;
        check("lat1_e1_ack", 256'(ack1), 256'(1));
        check("lat1_e1_data", data1, PAT_X);
        @(posedge clk); #1;
        check("lat1_e2_ack", 256'(ack1), 256'(0));
        check("lat1_e2_busy", 256'(busy1), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
